ad_ip_jesd204_tpl_adc_deframer: RTL and testbench

Receive-side transport-layer data path, the counterpart of the TPL DAC core. It accepts beats from the JESD204 RX link layer and deframes them into per-channel 16-bit samples. It then applies data-format conversion and runs a per-channel PN9/PN15 monitor. It sits between the JESD204 RX link layer and the ADC DMA/pack logic, with its configuration inputs driven by the TPL ADC regmap.

---
 rtl/ad_ip_jesd204_tpl_pkg.sv | 44 ++++
 rtl/ad_ip_jesd204_tpl_adc_pnmon.sv | 110 +++++++++++
 rtl/ad_ip_jesd204_tpl_adc_deframer.sv | 133 +++++++++++++
 tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_ip_jesd204_tpl_pkg.sv
// rtl/ad_ip_jesd204_tpl_pkg.sv - shared TPL types, PN constants and PN sequence step functions
//
// Contents:
//   PN_SEL_PN9 / PN_SEL_PN15 : adc_pn_sel encodings
//   PN_SYNC_CNT / PN_OOS_CNT : consecutive-beat thresholds of the PN lock state machine
//   pn_state_t               : PN monitor state (OOS, SYNC)
//   pn9_next / pn15_next     : next 16-bit sample of a PN stream, seeded from the current sample

package ad_ip_jesd204_tpl_pkg;

    localparam logic PN_SEL_PN9  = 1'b0;
    localparam logic PN_SEL_PN15 = 1'b1;

    localparam int PN_SYNC_CNT = 16;
    localparam int PN_OOS_CNT  = 64;

    typedef enum logic {
        OOS  = 1'b0,
        SYNC = 1'b1
    } pn_state_t;

    // Samples carry the bit stream MSB first. sr[0] is the most recent bit, so
    // after 16 shifts sr holds the following 16 stream bits in sample order.
    // x^9 + x^5 + 1 : s[n] = s[n-9] ^ s[n-5]
    function automatic logic [15:0] pn9_next(input logic [15:0] d);
        logic [15:0] sr;
        sr = d;
        for (int i = 0; i < 16; i++) begin
            sr = {sr[14:0], sr[8] ^ sr[4]};
        end
        return sr;
    endfunction

    // x^15 + x^14 + 1 : s[n] = s[n-15] ^ s[n-14]
    function automatic logic [15:0] pn15_next(input logic [15:0] d);
        logic [15:0] sr;
        sr = d;
        for (int i = 0; i < 16; i++) begin
            sr = {sr[14:0], sr[14] ^ sr[13]};
        end
        return sr;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_pnmon.sv
// rtl/ad_ip_jesd204_tpl_adc_pnmon.sv - per-channel self-synchronising PN9/PN15 monitor with lock state machine
//
// Ports:
//   clk, resetn  : link clock, synchronous active-low reset
//   enable       : channel enable; when low the monitor is held in OOS with counters cleared
//   valid        : beat valid (raw samples on data are meaningful)
//   pn_sel       : 0 = PN9, 1 = PN15; any change forces OOS and clears the counters
//   data         : DATA_PATH_WIDTH raw 16-bit samples, oldest in the LSBs
//   pn_oos       : registered out-of-sync flag
//   pn_err       : registered mismatch flag, high for one cycle per mismatching beat in SYNC

module ad_ip_jesd204_tpl_adc_pnmon
    import ad_ip_jesd204_tpl_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic                         valid,
    input  logic                         pn_sel,
    input  logic [16*DATA_PATH_WIDTH-1:0] data,
    output logic                         pn_oos,
    output logic                         pn_err
);

    localparam logic [4:0] SYNC_CNT = 5'(PN_SYNC_CNT);
    localparam logic [6:0] OOS_CNT  = 7'(PN_OOS_CNT);

    pn_state_t   state;
    logic [4:0]  match_cnt;
    logic [6:0]  mis_cnt;
    logic [15:0] last_sample;
    logic        has_prev;
    logic        pn_sel_d;
    logic        beat_match;

    // Each sample is predicted from its predecessor; sample 0 uses the last
    // sample of the previous valid beat. Right after reset there is no such
    // sample, so only the in-beat comparisons count for the first beat.
    always_comb begin
        logic [15:0] prev;
        logic [15:0] cur;
        logic [15:0] expd;
        beat_match = 1'b1;
        prev       = last_sample;
        cur        = '0;
        expd       = '0;
        for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
            cur  = data[16*i +: 16];
            expd = (pn_sel == PN_SEL_PN15) ? pn15_next(prev) : pn9_next(prev);
            if (((i != 0) || has_prev) && (cur != expd)) begin
                beat_match = 1'b0;
            end
            prev = cur;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= OOS;
            match_cnt   <= '0;
            mis_cnt     <= '0;
            last_sample <= '0;
            has_prev    <= 1'b0;
            pn_sel_d    <= PN_SEL_PN9;
            pn_oos      <= 1'b1;
            pn_err      <= 1'b0;
        end else begin
            pn_sel_d <= pn_sel;
            pn_err   <= 1'b0;

            // Keep tracking the stream while disabled so re-enabling does not
            // compare against a stale sample.
            if (valid) begin
                last_sample <= data[16*(DATA_PATH_WIDTH-1) +: 16];
                has_prev    <= 1'b1;
            end

            if (!enable || (pn_sel != pn_sel_d)) begin
                state     <= OOS;
                match_cnt <= '0;
                mis_cnt   <= '0;
                pn_oos    <= 1'b1;
            end else if (valid) begin
                if (beat_match) begin
                    mis_cnt <= '0;
                    if (match_cnt < SYNC_CNT) begin
                        match_cnt <= match_cnt + 5'd1;
                    end
                    if ((state == OOS) && (match_cnt >= SYNC_CNT - 5'd1)) begin
                        state  <= SYNC;
                        pn_oos <= 1'b0;
                    end
                end else begin
                    match_cnt <= '0;
                    if (mis_cnt < OOS_CNT) begin
                        mis_cnt <= mis_cnt + 7'd1;
                    end
                    pn_err <= (state == SYNC);
                    if ((state == SYNC) && (mis_cnt >= OOS_CNT - 7'd1)) begin
                        state  <= OOS;
                        pn_oos <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_deframer.sv
// rtl/ad_ip_jesd204_tpl_adc_deframer.sv - JESD204 RX transport layer: deframe lanes to channel samples, format, PN monitor
//
// Optional feature macro: AD_IP_JESD204_TPL_ADC_PNMON_EN (defined = PN monitors built,
// undefined = adc_pn_oos tied all-ones, adc_pn_err tied zero, adc_pn_sel ignored).
//
// Ports:
//   link_clk, link_resetn : the only clock; synchronous active-low reset
//   link_valid, link_data : link-layer beat, lane 0 in the LSBs, octet 0 of each lane in its LSBs
//   enable                : per-channel enable
//   adc_dfmt_enable/type/se : data-format controls (enable, offset-binary, sign-extend)
//   adc_pn_sel            : 0 = PN9, 1 = PN15
//   adc_valid, adc_data   : per-channel valid and samples, channel 0 / oldest sample in the LSBs
//   adc_pn_oos, adc_pn_err: per-channel PN monitor status

module ad_ip_jesd204_tpl_adc_deframer
    import ad_ip_jesd204_tpl_pkg::*;
#(
    parameter int NUM_LANES            = 4,
    parameter int NUM_CHANNELS         = 2,
    parameter int OCTETS_PER_BEAT      = 4,
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int BITS_PER_SAMPLE      = 16,
    parameter int DATA_PATH_WIDTH      = OCTETS_PER_BEAT*8*NUM_LANES/NUM_CHANNELS/16
) (
    input  logic                                     link_clk,
    input  logic                                     link_resetn,
    input  logic                                     link_valid,
    input  logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0]   link_data,
    input  logic [NUM_CHANNELS-1:0]                  enable,
    input  logic                                     adc_dfmt_enable,
    input  logic                                     adc_dfmt_type,
    input  logic                                     adc_dfmt_se,
    input  logic                                     adc_pn_sel,
    output logic [NUM_CHANNELS-1:0]                  adc_valid,
    output logic [NUM_CHANNELS*16*DATA_PATH_WIDTH-1:0] adc_data,
    output logic [NUM_CHANNELS-1:0]                  adc_pn_oos,
    output logic [NUM_CHANNELS-1:0]                  adc_pn_err
);

    localparam int LANE_W = 8 * OCTETS_PER_BEAT;
    localparam int LINK_W = NUM_LANES * LANE_W;
    localparam int F      = 2 * NUM_CHANNELS / NUM_LANES;
    localparam int CH_W   = 16 * DATA_PATH_WIDTH;

    if (BITS_PER_SAMPLE != 16) begin : g_bad_np
        $error("BITS_PER_SAMPLE must be 16");
    end
    if ((CONVERTER_RESOLUTION < 8) || (CONVERTER_RESOLUTION > 16)) begin : g_bad_n
        $error("CONVERTER_RESOLUTION must be within 8..16");
    end
    if ((F < 1) || ((2 * NUM_CHANNELS) % NUM_LANES != 0) || (OCTETS_PER_BEAT % F != 0) ||
        (DATA_PATH_WIDTH < 1) || (DATA_PATH_WIDTH != OCTETS_PER_BEAT / F)) begin : g_bad_geom
        $error("lane/channel/octet geometry does not give an integer frame layout");
    end

    logic              valid_s1;
    logic [LINK_W-1:0] data_s1;
    logic [CH_W-1:0]   raw [NUM_CHANNELS];
    logic [NUM_CHANNELS*CH_W-1:0] fmt_data;

    // Octet k of frame f: frame octets are spread F per lane, lane 0 first,
    // and a lane carries its frames back to back starting at octet 0.
    function automatic logic [7:0] frame_octet(input logic [LINK_W-1:0] d, input int k, input int f);
        return d[(k / F) * LANE_W + (f * F + k % F) * 8 +: 8];
    endfunction

    // Raw sample is MSB-aligned; bring it down to N bits, optionally flip the
    // offset-binary MSB, then sign- or zero-extend back to 16 bits.
    function automatic logic [15:0] format_sample(input logic [15:0] s, input logic dfmt_type,
                                                  input logic dfmt_se);
        logic [15:0] r;
        r = s >> (16 - CONVERTER_RESOLUTION);
        if (dfmt_type) begin
            r[CONVERTER_RESOLUTION-1] = ~r[CONVERTER_RESOLUTION-1];
        end
        for (int b = CONVERTER_RESOLUTION; b < 16; b++) begin
            r[b] = dfmt_se & r[CONVERTER_RESOLUTION-1];
        end
        return r;
    endfunction

    always_comb begin
        raw      = '{default: '0};
        fmt_data = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int f = 0; f < DATA_PATH_WIDTH; f++) begin
                // First octet of a sample is its MSB.
                raw[c][16*f +: 16] = {frame_octet(data_s1, 2*c, f), frame_octet(data_s1, 2*c + 1, f)};
                fmt_data[c*CH_W + 16*f +: 16] = adc_dfmt_enable ?
                    format_sample(raw[c][16*f +: 16], adc_dfmt_type, adc_dfmt_se) : raw[c][16*f +: 16];
            end
        end
    end

    always_ff @(posedge link_clk) begin
        if (!link_resetn) begin
            valid_s1  <= 1'b0;
            data_s1   <= '0;
            adc_valid <= '0;
            adc_data  <= '0;
        end else begin
            valid_s1  <= link_valid;
            data_s1   <= link_data;
            adc_valid <= {NUM_CHANNELS{valid_s1}} & enable;
            if (valid_s1) begin
                adc_data <= fmt_data;
            end
        end
    end

`ifdef AD_IP_JESD204_TPL_ADC_PNMON_EN
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_pnmon
        ad_ip_jesd204_tpl_adc_pnmon #(
            .DATA_PATH_WIDTH (DATA_PATH_WIDTH)
        ) u_pnmon (
            .clk    (link_clk),
            .resetn (link_resetn),
            .enable (enable[c]),
            .valid  (valid_s1),
            .pn_sel (adc_pn_sel),
            .data   (raw[c]),
            .pn_oos (adc_pn_oos[c]),
            .pn_err (adc_pn_err[c])
        );
    end
`else
    logic unused_pn_sel;
    assign unused_pn_sel = adc_pn_sel;
    assign adc_pn_oos    = '1;
    assign adc_pn_err    = '0;
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv
// tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv - directed self-checking bench for ad_ip_jesd204_tpl_adc_deframer

module tb_ad_ip_jesd204_tpl_adc_deframer;

`ifdef AD_IP_JESD204_TPL_ADC_PNMON_EN
    localparam bit PN_EN = 1'b1;
`else
    localparam bit PN_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         link_resetn;
    logic         link_valid;
    logic [127:0] link_data;
    logic [1:0]   enable;
    logic         adc_dfmt_enable;
    logic         adc_dfmt_type;
    logic         adc_dfmt_se;
    logic         adc_pn_sel;
    logic [1:0]   adc_valid;
    logic [127:0] adc_data;
    logic [1:0]   adc_pn_oos;
    logic [1:0]   adc_pn_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int p0;
    int p1;
    logic pnb [0:32767];

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_adc_deframer #(
        .CONVERTER_RESOLUTION (12)
    ) dut (
        .link_clk        (clk),
        .link_resetn     (link_resetn),
        .link_valid      (link_valid),
        .link_data       (link_data),
        .enable          (enable),
        .adc_dfmt_enable (adc_dfmt_enable),
        .adc_dfmt_type   (adc_dfmt_type),
        .adc_dfmt_se     (adc_dfmt_se),
        .adc_pn_sel      (adc_pn_sel),
        .adc_valid       (adc_valid),
        .adc_data        (adc_data),
        .adc_pn_oos      (adc_pn_oos),
        .adc_pn_err      (adc_pn_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] x_oos(input logic [1:0] v);
        return PN_EN ? v : 2'b11;
    endfunction

    function automatic logic [1:0] x_err(input logic [1:0] v);
        return PN_EN ? v : 2'b00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        link_valid = 1'b0;
        link_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // L=4, M=2, F=1: lane0 = ch0 MSBs, lane1 = ch0 LSBs, lane2 = ch1 MSBs, lane3 = ch1 LSBs,
    // frame f in octet f of every lane.
    function automatic logic [127:0] pack(input logic [63:0] c0, input logic [63:0] c1);
        logic [127:0] ld;
        ld = '0;
        for (int f = 0; f < 4; f++) begin
            ld[8*f +: 8]      = c0[16*f + 8 +: 8];
            ld[32 + 8*f +: 8] = c0[16*f +: 8];
            ld[64 + 8*f +: 8] = c1[16*f + 8 +: 8];
            ld[96 + 8*f +: 8] = c1[16*f +: 8];
        end
        return ld;
    endfunction

    function automatic logic [15:0] pn_word(input int k);
        logic [15:0] w;
        for (int b = 0; b < 16; b++) w[15-b] = pnb[16*k + b];
        return w;
    endfunction

    task automatic drive_pn(input bit corrupt);
        logic [63:0] c0;
        logic [63:0] c1;
        for (int i = 0; i < 4; i++) begin
            c0[16*i +: 16] = pn_word(p0 + i);
            c1[16*i +: 16] = pn_word(p1 + i);
        end
        if (corrupt) c0[15:0] = c0[15:0] ^ 16'h0001;
        p0 += 4;
        p1 += 4;
        link_data  = pack(c0, c1);
        link_valid = 1'b1;
    endtask

    // One valid beat followed by an invalid cycle; outputs then reflect that beat.
    task automatic pn_beat(input bit corrupt);
        drive_pn(corrupt);
        step();
        idle();
        step();
    endtask

    task automatic fmt_beat(input logic [63:0] c0, input logic [63:0] c1);
        link_data  = pack(c0, c1);
        link_valid = 1'b1;
        step();
        idle();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < 32768; n++) begin
            if (n < 9) pnb[n] = 1'b1;
            else       pnb[n] = pnb[n-9] ^ pnb[n-5];
        end
        p0 = 0;
        p1 = 1000;

        link_resetn     = 1'b0;
        link_valid      = 1'b0;
        link_data       = '0;
        enable          = 2'b11;
        adc_dfmt_enable = 1'b0;
        adc_dfmt_type   = 1'b0;
        adc_dfmt_se     = 1'b0;
        adc_pn_sel      = 1'b0;
        step();
        step();
        chk("rst_valid", adc_valid, 2'b00);
        chk("rst_data", adc_data, 128'h0);
        chk("rst_oos", adc_pn_oos, 2'b11);
        chk("rst_err", adc_pn_err, 2'b00);
        link_resetn = 1'b1;
        step();

        // Ramp through the JESD mapping, latency and hold
        link_data  = 128'h08070605_00000000_04030201_00000000;
        link_valid = 1'b1;
        step();
        chk("lat_cycle1_valid", adc_valid, 2'b00);
        idle();
        step();
        chk("lat_cycle2_valid", adc_valid, 2'b11);
        chk("ramp_data", adc_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        step();
        chk("valid_drop", adc_valid, 2'b00);
        chk("data_hold", adc_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);

        // Formatting, N = 12
        adc_dfmt_enable = 1'b1;
        adc_dfmt_type   = 1'b1;
        adc_dfmt_se     = 1'b1;
        fmt_beat(64'h1230_8000_FFF0_0000, 64'h7FF0_7FF0_7FF0_7FF0);
        chk("fmt_ob_se", adc_data, 128'hFFFF_FFFF_FFFF_FFFF_F923_0000_07FF_F800);
        adc_dfmt_se = 1'b0;
        fmt_beat(64'h1230_8000_FFF0_0000, 64'h7FF0_7FF0_7FF0_7FF0);
        chk("fmt_ob_nose", adc_data, 128'h0FFF_0FFF_0FFF_0FFF_0923_0000_07FF_0800);
        adc_dfmt_type = 1'b0;
        adc_dfmt_se   = 1'b1;
        fmt_beat(64'h1230_8000_FFF0_0000, 64'h7FF0_7FF0_7FF0_7FF0);
        chk("fmt_tc_se", adc_data, 128'h07FF_07FF_07FF_07FF_0123_F800_FFFF_0000);
        adc_dfmt_enable = 1'b0;
        adc_dfmt_se     = 1'b0;

        // PN9 lock: one priming beat, then 16 back-to-back matching beats
        pn_beat(1'b0);
        chk("prime_err", adc_pn_err, 2'b00);
        for (int b = 0; b < 16; b++) begin
            drive_pn(1'b0);
            step();
            chk($sformatf("lock_oos_%0d", b), adc_pn_oos, 2'b11);
            chk($sformatf("lock_err_%0d", b), adc_pn_err, 2'b00);
        end
        idle();
        step();
        chk("lock_oos_16", adc_pn_oos, x_oos(2'b00));
        chk("lock_err_16", adc_pn_err, 2'b00);

        // Single corrupt beat in SYNC
        for (int b = 0; b < 3; b++) pn_beat(1'b0);
        chk("sync_err_clean", adc_pn_err, 2'b00);
        pn_beat(1'b1);
        chk("single_err", adc_pn_err, x_err(2'b01));
        chk("single_oos", adc_pn_oos, x_oos(2'b00));
        pn_beat(1'b0);
        chk("single_after_err", adc_pn_err, 2'b00);

        // 64 consecutive corrupt beats on ch0
        for (int b = 1; b <= 64; b++) begin
            pn_beat(1'b1);
            chk($sformatf("run_err_%0d", b), adc_pn_err, x_err(2'b01));
            chk($sformatf("run_oos_%0d", b), adc_pn_oos, x_oos((b == 64) ? 2'b01 : 2'b00));
        end

        // Relock ch0 with invalid cycles between beats
        for (int j = 1; j <= 16; j++) begin
            pn_beat(1'b0);
            chk($sformatf("relock_oos_%0d", j), adc_pn_oos, x_oos((j < 16) ? 2'b01 : 2'b00));
            chk($sformatf("relock_err_%0d", j), adc_pn_err, 2'b00);
        end

        // Reset mid-stream while in SYNC
        drive_pn(1'b0);
        step();
        drive_pn(1'b0);
        link_resetn = 1'b0;
        step();
        chk("mid_rst_valid", adc_valid, 2'b00);
        chk("mid_rst_data", adc_data, 128'h0);
        chk("mid_rst_oos", adc_pn_oos, 2'b11);
        chk("mid_rst_err", adc_pn_err, 2'b00);
        link_resetn = 1'b1;
        idle();
        step();
        for (int j = 1; j <= 16; j++) begin
            pn_beat(1'b0);
            chk($sformatf("rst_relock_oos_%0d", j), adc_pn_oos, x_oos((j < 16) ? 2'b11 : 2'b00));
        end

        // Disabled channel
        enable = 2'b01;
        pn_beat(1'b0);
        chk("dis_valid", adc_valid, 2'b01);
        chk("dis_oos", adc_pn_oos, x_oos(2'b10));
        chk("dis_err", adc_pn_err, 2'b00);
        enable = 2'b11;

        // PN select change forces OOS
        adc_pn_sel = 1'b1;
        step();
        chk("pnsel_oos", adc_pn_oos, 2'b11);
        adc_pn_sel = 1'b0;
        step();
        chk("pnsel_err", adc_pn_err, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
